// File: rtl/sha256_id_arb.sv
// sha256_id_arb: packet-locked arbiter sharing the SHA-256 ID buffer input among NUM_REQ sources.
// Define SHA256_ID_ARB_FIXED_PRIO_EN for lowest-index fixed priority instead of round-robin.
//
// state  | meaning
// IDLE   | no grant held; pick a winner among valid requesters
// LOCKED | grant held until the granted requester's last beat is accepted
module sha256_id_arb #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 6,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    sync_rst,
    input  logic                    en,
    input  logic [NUM_REQ*ID_W-1:0] req_id,
    input  logic [NUM_REQ-1:0]      req_last,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [ID_W-1:0]         id_out,
    output logic                    id_out_last,
    output logic                    id_out_valid,
    input  logic                    id_out_ready,
    output logic [GW-1:0]           grant_idx,
    output logic                    busy,
    output logic [GW-1:0]           status_src,
    output logic [7:0]              pkt_cnt
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

    state_t          state, state_nxt;
    logic [GW-1:0]   winner, grant_nxt;
    logic [ID_W-1:0] sel_id;
    logic            sel_last, sel_valid;
    logic            can_load, in_hs, out_hs, pkt_done;

    always_comb begin
        sel_id    = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (GW'(k) == grant_idx) begin
                sel_id    = req_id[k*ID_W +: ID_W];
                sel_last  = req_last[k];
                sel_valid = req_valid[k];
            end
        end
    end

`ifdef SHA256_ID_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) winner = GW'(k);
        end
    end
`else
    logic [GW-1:0] rr_ptr;
    logic          rr_found;

    // Two passes give the rr_ptr+1 .. wrap .. rr_ptr search order.
    always_comb begin
        winner   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && req_valid[k] && (GW'(k) > rr_ptr)) begin
                winner   = GW'(k);
                rr_found = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && req_valid[k] && (GW'(k) <= rr_ptr)) begin
                winner   = GW'(k);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst)      rr_ptr <= LAST_IDX;
        else if (pkt_done) rr_ptr <= grant_idx;
    end
`endif

    assign can_load = (state == LOCKED) && en && (!id_out_valid || id_out_ready);
    assign in_hs    = can_load && sel_valid;
    assign out_hs   = id_out_valid && id_out_ready;
    assign pkt_done = in_hs && sel_last;
    assign busy     = (state == LOCKED);

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (GW'(k) == grant_idx) req_ready[k] = can_load;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_idx;
        case (state)
            IDLE: begin
                if (en && (|req_valid)) begin
                    state_nxt = LOCKED;
                    grant_nxt = winner;
                end
            end
            LOCKED: begin
                if (pkt_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            grant_idx    <= LAST_IDX;
            id_out       <= '0;
            id_out_last  <= 1'b0;
            id_out_valid <= 1'b0;
            status_src   <= '0;
            pkt_cnt      <= '0;
        end else begin
            grant_idx <= grant_nxt;
            if (in_hs) begin
                id_out       <= sel_id;
                id_out_last  <= sel_last;
                id_out_valid <= 1'b1;
            end else if (out_hs) begin
                id_out_valid <= 1'b0;
            end
            if (pkt_done) begin
                status_src <= grant_idx;
                pkt_cnt    <= pkt_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_sha256_id_arb.sv
// Self-checking bench for sha256_id_arb: directed scenarios plus randomized traffic
// against a packet-queue reference model of the arbiter.
`timescale 1ns/1ps
module tb_sha256_id_arb;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 6;
    localparam int GW      = $clog2(NUM_REQ);

    logic                    clk = 1'b0;
    logic                    sync_rst, en, id_out_ready;
    logic [NUM_REQ*ID_W-1:0] req_id;
    logic [NUM_REQ-1:0]      req_last, req_valid, req_ready;
    logic [ID_W-1:0]         id_out;
    logic                    id_out_last, id_out_valid, busy;
    logic [GW-1:0]           grant_idx, status_src;
    logic [7:0]              pkt_cnt;

    always #5 clk = ~clk;

    sha256_id_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .sync_rst(sync_rst), .en(en),
        .req_id(req_id), .req_last(req_last), .req_valid(req_valid), .req_ready(req_ready),
        .id_out(id_out), .id_out_last(id_out_last), .id_out_valid(id_out_valid),
        .id_out_ready(id_out_ready), .grant_idx(grant_idx), .busy(busy),
        .status_src(status_src), .pkt_cnt(pkt_cnt)
    );

    int vectors = 0, miscompares = 0, cyc = 0;
    bit rst_drv, en_drv, ordy_drv, rnd_valid, rnd_ordy, rnd_en;

    // Per-requester beat queues {last, id}, and the expected output stream.
    logic [ID_W:0] q [NUM_REQ][$];
    logic [ID_W:0] sb [$];
    int log_id[$], log_last[$], log_cyc[$];

    bit            m_locked, m_ov, m_last;
    int            m_grant, m_rr, m_src, m_cnt;
    logic [ID_W-1:0] m_id;

`ifdef SHA256_ID_ARB_FIXED_PRIO_EN
    int cont_exp[6]  = '{1, 1, 1, 1, 2, 2};
    int stall_exp[5] = '{7, 7, 20, 21, 22};
    int stall_grant  = 0;
`else
    int cont_exp[6]  = '{1, 1, 2, 2, 1, 1};
    int stall_exp[5] = '{20, 21, 22, 7, 7};
    int stall_grant  = 1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int rr);
`ifdef SHA256_ID_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
        for (int i = 1; i <= NUM_REQ; i++) begin
            int c = (rr + i) % NUM_REQ;
            if (v[c]) return c;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_ov = 0; m_last = 0; m_id = '0;
        m_grant = NUM_REQ - 1; m_rr = NUM_REQ - 1; m_src = 0; m_cnt = 0;
    endtask

    task automatic push_beat(input int k, input logic [ID_W-1:0] id, input bit last);
        q[k].push_back({last, id});
    endtask

    task automatic push_pkt(input int k, input logic [ID_W-1:0] id, input int len);
        for (int b = 0; b < len; b++) push_beat(k, id, b == len - 1);
    endtask

    task automatic clear_all();
        for (int k = 0; k < NUM_REQ; k++) q[k].delete();
        sb.delete();
        log_id.delete(); log_last.delete(); log_cyc.delete();
    endtask

    task automatic tick();
        logic [NUM_REQ-1:0] exp_ready, hs;
        bit out_hs;
        @(negedge clk);
        sync_rst     = rst_drv;
        en           = rnd_en ? ($urandom_range(0, 7) != 0) : en_drv;
        id_out_ready = rnd_ordy ? ($urandom_range(0, 3) != 0) : ordy_drv;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (q[k].size() > 0 && (!rnd_valid || $urandom_range(0, 4) != 0)) begin
                req_valid[k] = 1'b1;
                req_id[k*ID_W +: ID_W] = q[k][0][ID_W-1:0];
                req_last[k] = q[k][0][ID_W];
            end else begin
                req_valid[k] = 1'b0;
                req_id[k*ID_W +: ID_W] = '0;
                req_last[k] = 1'b0;
            end
        end
        #1;
        exp_ready = '0;
        if (m_locked && en && (!m_ov || id_out_ready)) exp_ready = NUM_REQ'(1) << m_grant;
        hs     = exp_ready & req_valid;
        out_hs = m_ov && id_out_ready;
        chk("req_ready",    32'(req_ready),    32'(exp_ready));
        chk("id_out_valid", 32'(id_out_valid), 32'(m_ov));
        chk("id_out",       32'(id_out),       32'(m_id));
        chk("id_out_last",  32'(id_out_last),  32'(m_last));
        chk("grant_idx",    32'(grant_idx),    32'(m_grant));
        chk("busy",         32'(busy),         32'(m_locked));
        chk("status_src",   32'(status_src),   32'(m_src));
        chk("pkt_cnt",      32'(pkt_cnt),      32'(m_cnt));
        if (id_out_valid === 1'b1 && id_out_ready) begin
            log_id.push_back(int'(id_out));
            log_last.push_back(int'(id_out_last));
            log_cyc.push_back(cyc);
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("sb_beat", 32'({id_out_last, id_out}), 32'(sb.pop_front()));
        end
        if (rst_drv) begin
            model_reset();
        end else begin
            if (!m_locked) begin
                if (en && (|req_valid)) begin
                    m_grant  = pick(req_valid, m_rr);
                    m_locked = 1;
                end
            end else if (hs != '0) begin
                m_id   = q[m_grant][0][ID_W-1:0];
                m_last = q[m_grant][0][ID_W];
                sb.push_back(q[m_grant][0]);
                if (m_last) begin
                    m_locked = 0;
                    m_rr     = m_grant;
                    m_src    = m_grant;
                    m_cnt    = (m_cnt + 1) % 256;
                end
            end
            if (hs != '0)  m_ov = 1;
            else if (out_hs) m_ov = 0;
        end
        for (int k = 0; k < NUM_REQ; k++) if (hs[k]) void'(q[k].pop_front());
        cyc++;
    endtask

    function automatic bit pending();
        bit p = m_locked || m_ov;
        for (int k = 0; k < NUM_REQ; k++) if (q[k].size() != 0) p = 1;
        return p;
    endfunction

    task automatic drain(input int max_cyc);
        int n = 0;
        rnd_valid = 0; rnd_ordy = 0; rnd_en = 0; en_drv = 1; ordy_drv = 1;
        while (pending() && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(n < max_cyc), 32'd1);
    endtask

    initial begin
        int t0;
        int pushed;
        rst_drv = 1; en_drv = 1; ordy_drv = 1; rnd_valid = 0; rnd_ordy = 0; rnd_en = 0;
        sync_rst = 1'b1; en = 1'b1; id_out_ready = 1'b1;
        req_valid = '0; req_id = '0; req_last = '0;
        model_reset();

        // Reset held with every requester valid.
        push_pkt(0, 6'd3, 2);
        push_pkt(1, 6'd4, 2);
        tick(); tick();
        chk("rst_grant", 32'(grant_idx), 32'(NUM_REQ - 1));
        chk("rst_ready", 32'(req_ready), 32'd0);
        clear_all();
        rst_drv = 0;

        // Single source, 3 beats of ID 5.
        push_pkt(0, 6'd5, 3);
        t0 = cyc;
        drain(50);
        chk("single_beats", 32'(log_id.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_id.size(); i++) begin
            chk("single_id", 32'(log_id[i]), 32'd5);
            chk("single_last", 32'(log_last[i]), 32'(i == 2));
        end
        if (log_cyc.size() > 0) chk("single_latency", 32'(log_cyc[0] - t0), 32'd2);
        chk("single_cnt", 32'(pkt_cnt), 32'd1);
        chk("single_src", 32'(status_src), 32'd0);

        // Contention from a fresh reset.
        rst_drv = 1; tick(); rst_drv = 0;
        clear_all();
        push_pkt(0, 6'd1, 2);
        push_pkt(1, 6'd2, 2);
        push_pkt(0, 6'd1, 2);
        drain(60);
        chk("cont_beats", 32'(log_id.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_id.size(); i++) chk("cont_id", 32'(log_id[i]), 32'(cont_exp[i]));
        if (log_cyc.size() >= 3) begin
            chk("cont_gap_beat", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
            chk("cont_gap_pkt",  32'(log_cyc[2] - log_cyc[1]), 32'd2);
        end

        // Backpressure for 3 cycles mid-packet.
        clear_all();
        for (int i = 0; i < 4; i++) push_beat(0, ID_W'(10 + i), i == 3);
        tick(); tick(); tick();
        ordy_drv = 0;
        repeat (3) begin
            tick();
            chk("bp_hold_id", 32'(id_out), 32'd11);
            chk("bp_hold_last", 32'(id_out_last), 32'd0);
            chk("bp_no_ready", 32'(req_ready), 32'd0);
        end
        drain(50);
        chk("bp_beats", 32'(log_id.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_id.size(); i++) begin
            chk("bp_id", 32'(log_id[i]), 32'(10 + i));
            chk("bp_last", 32'(log_last[i]), 32'(i == 3));
        end

        // Enable stall after beat 1 with the other requester waiting.
        clear_all();
        push_beat(1, 6'd20, 0); push_beat(1, 6'd21, 0); push_beat(1, 6'd22, 1);
        push_pkt(0, 6'd7, 2);
        tick(); tick();
        en_drv = 0;
        repeat (4) begin
            tick();
            chk("stall_grant", 32'(grant_idx), 32'(stall_grant));
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        drain(60);
        chk("stall_beats", 32'(log_id.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_id.size(); i++) chk("stall_id", 32'(log_id[i]), 32'(stall_exp[i]));

        // Reset pulse after beat 2 of 4.
        clear_all();
        for (int i = 0; i < 4; i++) push_beat(1, ID_W'(30 + i), i == 3);
        tick(); tick(); tick();
        rst_drv = 1; tick(); rst_drv = 0;
        clear_all();
        tick();
        chk("rstmid_valid", 32'(id_out_valid), 32'd0);
        chk("rstmid_cnt", 32'(pkt_cnt), 32'd0);
        push_pkt(0, 6'd40, 1);
        push_pkt(1, 6'd41, 1);
        tick(); tick();
        chk("rstmid_grant", 32'(grant_idx), 32'd0);
        drain(50);
        chk("rstmid_cnt2", 32'(pkt_cnt), 32'd2);

        // Randomized traffic with random valid gaps, backpressure and enable.
        clear_all();
        pushed = 0;
        rnd_valid = 1; rnd_ordy = 1; rnd_en = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (q[k].size() < 6 && $urandom_range(0, 2) == 0) begin
                    push_pkt(k, ID_W'($urandom_range(0, 63)), int'($urandom_range(1, 4)));
                    pushed++;
                end
            end
            tick();
        end
        drain(500);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);
        chk("rand_pkt_cnt", 32'(pkt_cnt), 32'((2 + pushed) % 256));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sha256_id_arb.md
# sha256_id_arb

Packet-locked arbiter that shares the single input port of the SHA-256 ID buffer between several ID sources (e.g. message builder and config/host path). Each requester presents 6-bit ID beats with a `last` flag on a valid/ready interface. The arbiter grants one requester at a time and holds the grant until that requester's `last` beat is accepted. The selected stream passes through a one-entry output register into the ID buffer's `id_in` port.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters; legal range 2..4.
- `ID_W`, 6, ID width in bits.
- `GW`, `$clog2(NUM_REQ)`, grant index width; derived, do not override.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `sync_rst` in 1: synchronous, active-high reset.
- `en` in 1: global enable; when low, no new grant is issued and no input beat is accepted.
- `req_id` in NUM_REQ*ID_W: packed IDs; requester k occupies bits [k*ID_W +: ID_W].
- `req_last` in NUM_REQ: per-requester last-beat flag.
- `req_valid` in NUM_REQ: per-requester valid.
- `req_ready` out NUM_REQ: per-requester ready. At most one bit is high in any cycle.
- `id_out` out ID_W: registered ID towards `id_in` of the ID buffer.
- `id_out_last` out 1: registered last flag.
- `id_out_valid` out 1: output valid.
- `id_out_ready` in 1: downstream ready.
- `grant_idx` out GW: index of the current or last granted requester.
- `busy` out 1: high while in LOCKED state.
- `status_src` out GW: source of the most recently completed packet.
- `pkt_cnt` out 8: count of completed packets; wraps at 255 to 0.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE, with `en`=1 and any `req_valid` set:
  - Select the winner and register it into `grant_idx`.
  - Go to LOCKED next cycle.
  - All `req_ready` stay 0 during IDLE.
- IDLE, with `en`=0 or no `req_valid`: stay in IDLE.
- Winner selection in the default build is round-robin. Search starts at `rr_ptr+1` and wraps modulo NUM_REQ. The first index with `req_valid` set wins.
- LOCKED:
  - `req_ready[grant_idx]` = `en` & (!`id_out_valid` | `id_out_ready`); all other ready bits are 0.
  - An input handshake loads `req_id`/`req_last` of the granted requester into the output register and sets `id_out_valid`.
- Input handshake with `req_last`=1:
  - Next state is IDLE.
  - `rr_ptr` <= `grant_idx`.
  - `status_src` <= `grant_idx`.
  - `pkt_cnt` <= `pkt_cnt`+1 (mod 256).
- Output register:
  - `id_out_valid` clears on an output handshake unless a new input beat is loaded in the same cycle.
  - While valid and not ready, `id_out`/`id_out_last` hold stable.
- The grant is held while the granted requester drops `req_valid` mid-packet. Other requesters wait.
- `en`=0 in LOCKED:
  - Grant is retained and `req_ready` is 0.
  - The output register still drains to downstream.
- A requester whose `req_valid` deasserts before it is granted is simply not selected.
- `busy` = (state == LOCKED).

## Timing
- Reset values:
  - state IDLE.
  - `req_ready` 0, `id_out_valid` 0, `id_out` 0, `id_out_last` 0.
  - `grant_idx` NUM_REQ-1 and `rr_ptr` NUM_REQ-1, so requester 0 wins first.
  - `status_src` 0, `pkt_cnt` 0, `busy` 0.
- Arbitration latency: `req_valid` seen in IDLE at cycle N gives `req_ready` high at N+1. The first `id_out_valid` follows at N+2 if the consumer is ready.
- Throughput: one beat per cycle in LOCKED with `id_out_ready` held 1.
- Packet gap: there is exactly one idle (IDLE-state) cycle between packets.
- Last beat accepted and new requests present in the same cycle: the new request is arbitrated in the following IDLE cycle, using the updated `rr_ptr`.
- `sync_rst` mid-packet: all state returns to reset values on the next edge. The partial packet in the output register is dropped; no `last` is emitted for it.
- `sync_rst` has priority over all other inputs.

## Configuration
- `SHA256_ID_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest-index valid requester always wins in IDLE, and `rr_ptr` is unused. Packet locking is unchanged.
- Not defined: round-robin as described above.

## Test plan
- Reset: hold `sync_rst`=1 for 2 cycles with all `req_valid`=1 -> `req_ready`=0, `id_out_valid`=0, `pkt_cnt`=0, `grant_idx`=1 (NUM_REQ=2).
- Single source: req0 sends 3 beats of ID 5, with last on beat 3; `id_out_ready`=1 -> `id_out`=5,5,5 with last on the 3rd beat; first valid 2 cycles after `req_valid`; `pkt_cnt`=1, `status_src`=0.
- Contention: req0 (2 beats, ID 1) and req1 (2 beats, ID 2) both valid, both re-request after completing -> output 1,1,2,2,1,1 with one idle cycle between packets. Under `SHA256_ID_ARB_FIXED_PRIO_EN`: req0 is served before req1 each round.
- Backpressure: `id_out_ready`=0 for 3 cycles mid-packet -> `id_out`/`id_out_last` stable, at most one beat absorbed, no loss or duplication against the reference sequence.
- Enable stall: `en`=0 for 4 cycles after beat 1 of a 3-beat req1 packet, with req0 valid -> no handshakes; `grant_idx` stays 1; req1 completes after `en` returns, then req0 is served.
- Reset mid-packet: `sync_rst` pulse after beat 2 of 4 -> `id_out_valid`=0 next cycle; the next packet is granted to req0 and `pkt_cnt` restarts from 0.
